// File: rtl/tick_div_ctrl.sv
// tick_div_ctrl: two-stage programmable tick divider with a limit-update handshake.
// Stage 1 divides F1 by act_lim1 (tick1 pulse, F2 square wave); stage 2 divides
// the stage-1 wraps by act_lim2 (tick2 pulse, F3 square wave). New limit pairs
// are applied directly in IDLE, or held pending in RUN until the next stage-2 wrap.
// Ports:
//   F1         clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   en         run enable (1 = count, 0 = idle)
//   cfg_valid  limit pair offered; cfg_lim1/cfg_lim2 requested limits
//   cfg_ready  block can accept a pair
//   cfg_err    one-cycle pulse: accepted pair had a zero limit and was dropped
//   tick1/2    one-cycle pulses at the stage-1 / stage-2 wrap
//   F2/F3      square waves toggling on tick1 / tick2 (data, never used as clocks)
//   busy       high while RUN or PEND
module tick_div_ctrl #(
  parameter int unsigned W        = 26,
  parameter int unsigned LIM1_DEF = 25000000,
  parameter int unsigned LIM2_DEF = 2
) (
  input  logic         F1,
  input  logic         rst_n,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_lim1,
  input  logic [W-1:0] cfg_lim2,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         tick1,
  output logic         tick2,
  output logic         F2,
  output logic         F3,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

  state_e       st_q, st_d;
  logic [W-1:0] cnt1_q, cnt1_d;
  logic [W-1:0] cnt2_q, cnt2_d;
  logic [W-1:0] act1_q, act1_d;
  logic [W-1:0] act2_q, act2_d;
  logic [W-1:0] pend1_q, pend1_d;
  logic [W-1:0] pend2_q, pend2_d;
  logic         tick1_q, tick1_d;
  logic         tick2_q, tick2_d;
  logic         f2_q, f2_d;
  logic         f3_q, f3_d;
  logic         err_q, err_d;
  logic         ready_q, ready_d;
  logic         busy_q, busy_d;

  // Handshake qualification; ready_q is the registered cfg_ready output.
  logic xfer_c, bad_c, good_c;
  logic wrap1_c, wrap2_c;

  assign xfer_c  = cfg_valid & ready_q;
  assign bad_c   = xfer_c & ((cfg_lim1 == '0) | (cfg_lim2 == '0));
  assign good_c  = xfer_c & ~bad_c;
  // Limits are never zero, so act-1 cannot underflow.
  assign wrap1_c = (cnt1_q == act1_q - W'(1));
  assign wrap2_c = wrap1_c & (cnt2_q == act2_q - W'(1));

  // State register and all output/datapath registers.
  always_ff @(posedge F1) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      act1_q  <= W'(LIM1_DEF);
      act2_q  <= W'(LIM2_DEF);
      pend1_q <= '0;
      pend2_q <= '0;
      tick1_q <= 1'b0;
      tick2_q <= 1'b0;
      f2_q    <= 1'b0;
      f3_q    <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      tick1_q <= tick1_d;
      tick2_q <= tick2_d;
      f2_q    <= f2_d;
      f3_q    <= f3_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, counter and output logic.
  always_comb begin
    logic do_count;
    st_d     = st_q;
    cnt1_d   = cnt1_q;
    cnt2_d   = cnt2_q;
    act1_d   = act1_q;
    act2_d   = act2_q;
    pend1_d  = pend1_q;
    pend2_d  = pend2_q;
    tick1_d  = 1'b0;
    tick2_d  = 1'b0;
    f2_d     = f2_q;
    f3_d     = f3_q;
    err_d    = bad_c;
    do_count = 1'b0;

    case (st_q)
      ST_IDLE: begin
        cnt1_d = '0;
        cnt2_d = '0;
        if (good_c) begin
          act1_d = cfg_lim1;
          act2_d = cfg_lim2;
        end
        if (en) st_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en) begin
          st_d   = ST_IDLE;
          cnt1_d = '0;
          cnt2_d = '0;
          // Going idle anyway, so a pair accepted now can take effect at once.
          if (good_c) begin
            act1_d = cfg_lim1;
            act2_d = cfg_lim2;
          end
        end else begin
          do_count = 1'b1;
          // Stored after this edge, so a wrap at this same edge does not apply it.
          if (good_c) begin
            pend1_d = cfg_lim1;
            pend2_d = cfg_lim2;
            st_d    = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!en) begin
          st_d    = ST_IDLE;
          cnt1_d  = '0;
          cnt2_d  = '0;
          act1_d  = pend1_q;
          act2_d  = pend2_q;
          pend1_d = '0;
          pend2_d = '0;
        end else begin
          do_count = 1'b1;
          if (wrap2_c) begin
            act1_d  = pend1_q;
            act2_d  = pend2_q;
            pend1_d = '0;
            pend2_d = '0;
            st_d    = ST_RUN;
          end
        end
      end
      default: begin
        st_d   = ST_IDLE;
        cnt1_d = '0;
        cnt2_d = '0;
      end
    endcase

    // Cascaded divide: stage 2 advances only on a stage-1 wrap.
    if (do_count) begin
      if (wrap1_c) begin
        cnt1_d  = '0;
        tick1_d = 1'b1;
        f2_d    = ~f2_q;
        if (wrap2_c) begin
          cnt2_d  = '0;
          tick2_d = 1'b1;
          f3_d    = ~f3_q;
        end else begin
          cnt2_d = cnt2_q + W'(1);
        end
      end else begin
        cnt1_d = cnt1_q + W'(1);
      end
    end

    ready_d = (st_d != ST_PEND);
    busy_d  = (st_d != ST_IDLE);
  end

  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign tick1     = tick1_q;
  assign tick2     = tick2_q;
  assign F2        = f2_q;
  assign F3        = f3_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tick_div_ctrl.sv
// Testbench for tick_div_ctrl (W=8, defaults 3/2): directed stimulus, an
// arithmetic reference model compared every cycle, and literal period checks.
module tb_tick_div_ctrl;

  localparam int unsigned W = 8;

  logic         F1;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_lim1;
  logic [W-1:0] cfg_lim2;
  logic         cfg_ready;
  logic         cfg_err;
  logic         tick1;
  logic         tick2;
  logic         F2;
  logic         F3;
  logic         busy;

  tick_div_ctrl #(.W(W), .LIM1_DEF(3), .LIM2_DEF(2)) dut (
    .F1(F1), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid),
    .cfg_lim1(cfg_lim1), .cfg_lim2(cfg_lim2), .cfg_ready(cfg_ready),
    .cfg_err(cfg_err), .tick1(tick1), .tick2(tick2), .F2(F2), .F3(F3),
    .busy(busy)
  );

  initial F1 = 1'b0;
  always #5 F1 = ~F1;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: k counts cycles since the run (or the last limit switch)
  // began; tick1 every a1 cycles, tick2 every a1*a2 cycles.
  typedef struct {
    bit     run, pend;
    longint a1, a2, p1, p2, k;
    bit     t1, t2, f2, f3, err, rdy, bsy;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_next(mdl_t c, bit rn, bit e, bit v, longint l1, longint l2);
    mdl_t n;
    bit   xfer, bad, good;
    n = c;
    if (!rn) begin
      n = '{default: 0};
      n.a1 = 3;
      n.a2 = 2;
      return n;
    end
    xfer  = v && c.rdy;
    bad   = xfer && (l1 == 0 || l2 == 0);
    good  = xfer && !bad;
    n.err = bad;
    n.t1  = 0;
    n.t2  = 0;
    if (!c.run) begin
      if (good) begin n.a1 = l1; n.a2 = l2; end
      if (e) begin n.run = 1; n.k = 0; end
    end else if (!e) begin
      n.run = 0;
      n.k   = 0;
      if (c.pend) begin n.a1 = c.p1; n.a2 = c.p2; n.pend = 0; end
      else if (good) begin n.a1 = l1; n.a2 = l2; end
    end else begin
      n.k = c.k + 1;
      if (n.k % c.a1 == 0) begin n.t1 = 1; n.f2 = !c.f2; end
      if (n.k % (c.a1 * c.a2) == 0) begin
        n.t2 = 1;
        n.f3 = !c.f3;
        n.k  = 0;
        if (c.pend) begin n.a1 = c.p1; n.a2 = c.p2; n.pend = 0; end
      end
      if (good) begin n.p1 = l1; n.p2 = l2; n.pend = 1; end
    end
    n.rdy = !n.pend;
    n.bsy = n.run;
    return n;
  endfunction

  always @(posedge F1)
    m <= mdl_next(m, rst_n, en, cfg_valid, longint'(cfg_lim1), longint'(cfg_lim2));

  // Per-cycle comparison against the model.
  always @(negedge F1) begin
    if (chk_en) begin
      check("m_tick1", tick1, m.t1);
      check("m_tick2", tick2, m.t2);
      check("m_F2", F2, m.f2);
      check("m_F3", F3, m.f3);
      check("m_cfg_ready", cfg_ready, m.rdy);
      check("m_cfg_err", cfg_err, m.err);
      check("m_busy", busy, m.bsy);
    end
  end

  task automatic step();
    @(negedge F1);
  endtask

  // Cycles until the next tick pulse; -1 if the budget runs out.
  task automatic wait_pulse(input bit sel2, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge F1);
      if ((sel2 ? tick2 : tick1) === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic offer(input int l1, input int l2);
    cfg_lim1  = W'(l1);
    cfg_lim2  = W'(l2);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic period(input string name, input bit sel2, input int exp);
    int n;
    wait_pulse(sel2, 64, n);
    wait_pulse(sel2, 64, n);
    check(name, n, exp);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_lim1  = '0;
    cfg_lim2  = '0;
    step();
    step();
    chk_en = 1'b1;
    check("rst_ready", cfg_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_F2F3", {F2, F3}, 0);

    rst_n = 1'b1;
    step();
    check("ready_after_rst", cfg_ready, 1);

    // Default limits 3/2.
    en = 1'b1;
    step();
    check("run_busy", busy, 1);
    wait_pulse(1'b0, 64, n);
    check("first_tick1_lat", n, 3);
    period("def_tick1_per", 1'b0, 3);
    period("def_tick2_per", 1'b1, 6);

    // Zero limit rejected while running.
    offer(0, 7);
    check("err_pulse", cfg_err, 1);
    check("err_ready", cfg_ready, 1);
    step();
    check("err_clear", cfg_err, 0);
    check("err_busy", busy, 1);
    period("err_tick1_per", 1'b0, 3);

    // Pending pair (5,1) applied at the next tick2.
    wait_pulse(1'b0, 64, n);
    step();
    offer(5, 1);
    check("pend_ready", cfg_ready, 0);
    wait_pulse(1'b1, 64, n);
    check("pend_ready_back", cfg_ready, 1);
    period("new_tick1_per", 1'b0, 5);
    period("new_tick2_per", 1'b1, 5);

    // Idle, load (1,4), run.
    en = 1'b0;
    step();
    check("idle_busy", busy, 0);
    offer(1, 4);
    check("idle_load_busy", busy, 0);
    en = 1'b1;
    step();
    wait_pulse(1'b0, 64, n);
    check("lim1_first_tick", n, 1);
    period("lim1_tick1_per", 1'b0, 1);
    period("lim1_tick2_per", 1'b1, 4);

    // Pending pair applied by dropping en.
    offer(2, 3);
    check("pend2_ready", cfg_ready, 0);
    en = 1'b0;
    step();
    check("pend_drop_busy", busy, 0);
    check("pend_drop_ready", cfg_ready, 1);
    step();
    en = 1'b1;
    step();
    wait_pulse(1'b0, 64, n);
    check("reen_first_tick", n, 2);
    period("reen_tick1_per", 1'b0, 2);
    period("reen_tick2_per", 1'b1, 6);

    // Reset during PEND discards the pair.
    offer(5, 1);
    check("pend3_ready", cfg_ready, 0);
    rst_n = 1'b0;
    step();
    check("rst_pend_ready", cfg_ready, 0);
    check("rst_pend_busy", busy, 0);
    check("rst_pend_F", {F2, F3, tick1, tick2, cfg_err}, 0);
    rst_n = 1'b1;
    step();
    wait_pulse(1'b0, 64, n);
    check("post_rst_first_tick", n, 3);
    period("post_rst_tick1_per", 1'b0, 3);
    period("post_rst_tick2_per", 1'b1, 6);

    chk_en = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tick_div_ctrl.md
TICK_DIV_CTRL -- requirements
Module: tick_div_ctrl

Interface
REQ-001 Parameter W, default 26: width of both divide counters and limit fields.
REQ-002 Parameter LIM1_DEF, default 25000000: stage-1 limit after reset; SHALL be nonzero and fit in W bits.
REQ-003 Parameter LIM2_DEF, default 2: stage-2 limit after reset; SHALL be nonzero and fit in W bits.
REQ-004 F1  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  run enable; 1 = count, 0 = idle.
REQ-007 cfg_valid  input  1  new limit pair offered.
REQ-008 cfg_lim1  input  W  requested stage-1 limit.
REQ-009 cfg_lim2  input  W  requested stage-2 limit.
REQ-010 cfg_ready  output  1  block can accept a limit pair.
REQ-011 cfg_err  output  1  one-cycle pulse: offered pair rejected.
REQ-012 tick1  output  1  one-cycle pulse at stage-1 wrap.
REQ-013 tick2  output  1  one-cycle pulse at stage-2 wrap.
REQ-014 F2  output  1  square wave, toggles on each tick1.
REQ-015 F3  output  1  square wave, toggles on each tick2.
REQ-016 busy  output  1  high in RUN or PEND.

Function
REQ-017 All outputs SHALL be registered; F2/F3 are data signals in the F1 domain and SHALL never clock logic.
REQ-018 States: IDLE, RUN, PEND; busy = (state != IDLE).
REQ-019 Stage 1: in RUN/PEND, cnt1 increments each cycle; when cnt1 == act_lim1-1, cnt1 -> 0, tick1 = 1 next cycle, F2 toggles.
REQ-020 Stage 2: cnt2 increments only on stage-1 wrap; when stage-1 wraps with cnt2 == act_lim2-1, cnt2 -> 0, tick2 = 1, F3 toggles, same cycle as tick1.
REQ-021 Period: tick1 every act_lim1 cycles; tick2 every act_lim1*act_lim2 cycles; F2 period 2*act_lim1; F3 period 2*act_lim1*act_lim2.
REQ-022 Limit 1 SHALL be legal: act_lim1 = 1 gives tick1 every cycle and F2 toggling every cycle.
REQ-023 Handshake: transfer when cfg_valid && cfg_ready at a rising edge; cfg_lim1/cfg_lim2 sampled that edge only.
REQ-024 cfg_ready = 1 in IDLE and RUN, 0 in PEND and during reset.
REQ-025 A transferred pair with either limit == 0 SHALL be dropped, cfg_err pulses next cycle, state and active limits unchanged.
REQ-026 IDLE + valid transfer: act_lim1/act_lim2 updated next cycle; state stays IDLE.
REQ-027 RUN + valid transfer: pair stored in pend registers, state -> PEND.
REQ-028 PEND: at next stage-2 wrap, pend limits become active and state -> RUN; counting after that wrap uses new limits.
REQ-029 Transfer in same cycle as a stage-2 wrap in RUN: pair waits for the following stage-2 wrap, not the current one.
REQ-030 IDLE -> RUN when en = 1; counting starts from cnt1 = cnt2 = 0 that cycle.
REQ-031 RUN/PEND with en = 0: next cycle state -> IDLE, cnt1 = cnt2 = 0, no tick; in PEND the pending pair becomes active at that same edge.
REQ-032 IDLE: counters held at 0, tick1 = tick2 = 0, F2/F3 hold last value.
REQ-033 Counter arithmetic SHALL be W-bit unsigned; compare against act_lim-1 with no overflow path since limits are nonzero.

Reset
REQ-034 rst_n = 0 at a rising edge: state IDLE, cnt1 = cnt2 = 0, F2 = F3 = 0, tick1 = tick2 = 0, cfg_err = 0, cfg_ready = 0, busy = 0, act_lim1 = LIM1_DEF, act_lim2 = LIM2_DEF, pend registers cleared.
REQ-035 Reset mid-operation (RUN or PEND) SHALL discard any pending pair and override all other inputs that cycle.
REQ-036 First cycle after rst_n = 1: cfg_ready = 1.

Verification
REQ-037 W=8, LIM1_DEF=3, LIM2_DEF=2, en held 1 after reset -> tick1 every 3 cycles, tick2 every 6, F2 period 6, F3 period 12.
REQ-038 In IDLE offer (1,4), then en = 1 -> tick1 every cycle, F2 toggles every cycle, tick2 every 4 cycles.
REQ-039 In RUN with (3,2), offer (5,1) mid-period -> cfg_ready 0 until next tick2; thereafter tick1 and tick2 every 5 cycles together.
REQ-040 Offer (0,7) in RUN -> cfg_err one-cycle pulse, state stays RUN, periods unchanged.
REQ-041 In PEND, drop en -> IDLE next cycle, counters 0, F2/F3 hold; re-enable -> new limits in effect from first cycle.
REQ-042 Assert rst_n = 0 during PEND -> all REQ-034 values next cycle; default limits, not pending pair, apply after restart.
